// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared types and flush encodings for the fetch-PC redirect controller.
// Flush vectors are {ex, id, if}.
package pc_redirect_ctrl_pkg;

    typedef enum logic [2:0] {
        RS_NONE,
        RS_IRQ,
        RS_ERET,
        RS_BR,
        RS_JMP
    } redirect_src_t;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        PENDING
    } redir_state_t;

    localparam logic [2:0] FL_NONE = 3'b000;
    localparam logic [2:0] FL_IRQ  = 3'b111;
    localparam logic [2:0] FL_ERET = 3'b001;
    localparam logic [2:0] FL_BR   = 3'b011;
    localparam logic [2:0] FL_JMP  = 3'b001;
    localparam logic [2:0] FL_ALL  = 3'b111;

    function automatic logic [2:0] src_flush(input redirect_src_t s);
        logic [2:0] f;
        f = FL_NONE;
        unique case (s)
            RS_IRQ:  f = FL_IRQ;
            RS_ERET: f = FL_ERET;
            RS_BR:   f = FL_BR;
            RS_JMP:  f = FL_JMP;
            default: f = FL_NONE;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/pc_redirect_ctrl_prio_sel.sv
// Fixed-priority redirect arbiter: irq > eret > br > jmp.
// Purely combinational; losing requests are simply dropped.
module redirect_prio_sel
    import pc_redirect_ctrl_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            irq_req,
    input  logic            eret_req,
    input  logic            br_req,
    input  logic            jmp_req,
    input  logic [XLEN-1:0] handler_base,
    input  logic [XLEN-1:0] epc,
    input  logic [XLEN-1:0] br_target,
    input  logic [XLEN-1:0] jmp_target,
    output redirect_src_t   src,
    output logic [XLEN-1:0] target,
    output logic [2:0]      flush
);

    always_comb begin
        src    = RS_NONE;
        target = '0;
        priority case (1'b1)
            irq_req: begin
                src    = RS_IRQ;
                target = handler_base;
            end
            eret_req: begin
                src    = RS_ERET;
                target = epc;
            end
            br_req: begin
                src    = RS_BR;
                target = br_target;
            end
            jmp_req: begin
                src    = RS_JMP;
                target = jmp_target;
            end
            default: begin
                src    = RS_NONE;
                target = '0;
            end
        endcase
        flush = src_flush(src);
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Architectural fetch-PC owner: sequential advance, prioritised redirects,
// pending redirects while fetch is busy, and the handler-base register.
module pc_redirect_ctrl
    import pc_redirect_ctrl_pkg::*;
#(
    parameter int              XLEN       = 64,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter logic [XLEN-1:0] HANDLER_PC = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            fetch_ready,
    input  logic            stall,
    input  logic            irq_take,
    input  logic            eret,
    input  logic [XLEN-1:0] epc,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            jmp_valid,
    input  logic [XLEN-1:0] jmp_target,
    input  logic            cfg_we,
    input  logic [XLEN-1:0] cfg_wdata,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    output logic            flush_if,
    output logic            flush_id,
    output logic            flush_ex,
    output logic            redirect_pend,
    output logic [XLEN-1:0] handler_base,
    output logic            misaligned
);

    redir_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic [XLEN-1:0] hb_q, hb_d;
    logic            mis_q, mis_d;

    logic            in_run, in_pend;
    redirect_src_t   sel_src;
    logic [XLEN-1:0] sel_target;
    logic [2:0]      sel_flush;
    logic [2:0]      flush_v;
    logic [XLEN-1:0] pend_ld;

    assign in_run  = (state_q == RUN);
    assign in_pend = (state_q == PENDING);

    // Only an interrupt may override a waiting redirect; the rest are wrong-path.
    redirect_prio_sel #(.XLEN(XLEN)) u_sel (
        .irq_req      (irq_take & (in_run | in_pend)),
        .eret_req     (eret & in_run),
        .br_req       (br_taken & in_run),
        .jmp_req      (jmp_valid & in_run),
        .handler_base (hb_q),
        .epc          (epc),
        .br_target    (br_target),
        .jmp_target   (jmp_target),
        .src          (sel_src),
        .target       (sel_target),
        .flush        (sel_flush)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
        mis_d     = 1'b0;
        flush_v   = sel_flush;
        pend_ld   = (sel_src == RS_IRQ) ? sel_target : pend_pc_q;
        hb_d      = cfg_we ? (cfg_wdata & ~XLEN'(3)) : hb_q;
        unique case (state_q)
            BOOT: begin
                state_d = RUN;
                flush_v = FL_ALL;
            end
            RUN: begin
                if (sel_src != RS_NONE) begin
                    if (fetch_ready) begin
                        pc_d  = sel_target;
                        mis_d = |sel_target[1:0];
                    end else begin
                        pend_pc_d = sel_target;
                        state_d   = PENDING;
                    end
                end else if (fetch_ready && !stall) begin
                    pc_d = pc_q + XLEN'(4);
                end
            end
            PENDING: begin
                if (fetch_ready) begin
                    pc_d    = pend_ld;
                    mis_d   = |pend_ld[1:0];
                    state_d = RUN;
                end else begin
                    pend_pc_d = pend_ld;
                end
            end
            default: begin
                state_d = BOOT;
                flush_v = FL_ALL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= BOOT;
            pc_q      <= RESET_PC;
            pend_pc_q <= RESET_PC;
            hb_q      <= HANDLER_PC;
            mis_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
            hb_q      <= hb_d;
            mis_q     <= mis_d;
        end
    end

    assign pc            = pc_q;
    assign pc_valid      = in_run;
    assign redirect_pend = in_pend;
    assign handler_base  = hb_q;
    assign misaligned    = mis_q;
    assign flush_if      = flush_v[0];
    assign flush_id      = flush_v[1];
    assign flush_ex      = flush_v[2];

endmodule
